// File: rtl/program_loader.sv
// Byte-stream program loader: assembles big-endian byte pairs into words and writes them to program memory.
// Optional trailing XOR checksum byte is enabled with `define PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
    parameter int                   RAM_WIDTH = 16,
    parameter int                   RAM_DEPTH = 2048,
    parameter logic [RAM_WIDTH-1:0] HALT_WORD = 16'h0000,
    localparam int                  ADDR_W    = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1
) (
    input  logic                 clka,
    input  logic                 rsta_n,
    input  logic                 start,
    input  logic [7:0]           rx_data,
    input  logic                 rx_valid,
    output logic                 rx_ready,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [RAM_WIDTH-1:0] wr_data,
    output logic                 wr_en,
    output logic                 busy,
    output logic                 done,
    output logic                 overflow,
    output logic [ADDR_W:0]      word_count,
    output logic                 chk_err
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HI,
        S_LO,
        S_WRITE,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        S_CHK,
`endif
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [ADDR_W-1:0]      r_addr;
    logic [7:0]             r_hi;
    logic [ADDR_W-1:0]      r_wrAddr;
    logic [RAM_WIDTH-1:0]   r_wrData;
    logic                   r_wrEn;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_overflow;
    logic [ADDR_W:0]        r_wordCount;
    logic                   w_xfer;
    logic                   w_isHalt;
    logic                   w_lastAddr;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]             r_xor;
    logic                   r_chkErr;

    assign rx_ready = (r_state == S_HI) || (r_state == S_LO) || (r_state == S_CHK);
    assign chk_err  = r_chkErr;
`else
    assign rx_ready = (r_state == S_HI) || (r_state == S_LO);
    assign chk_err  = 1'b0;
`endif

    assign w_xfer     = rx_valid && rx_ready;
    assign w_isHalt   = (r_wrData == HALT_WORD);
    assign w_lastAddr = (r_addr == LAST_ADDR);

    assign wr_addr    = r_wrAddr;
    assign wr_data    = r_wrData;
    assign wr_en      = r_wrEn;
    assign busy       = r_busy;
    assign done       = r_done;
    assign overflow   = r_overflow;
    assign word_count = r_wordCount;

    // The write port registers are loaded on the low-byte transfer so the
    // strobe lands in WRITE and address/data stay put between writes.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_hi        <= '0;
            r_wrAddr    <= '0;
            r_wrData    <= '0;
            r_wrEn      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
            r_wordCount <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_xor       <= '0;
            r_chkErr    <= 1'b0;
`endif
        end else begin
            r_wrEn <= 1'b0;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_addr      <= '0;
                        r_wordCount <= '0;
                        r_done      <= 1'b0;
                        r_overflow  <= 1'b0;
                        r_busy      <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_xor       <= '0;
                        r_chkErr    <= 1'b0;
`endif
                        r_state     <= S_HI;
                    end
                end
                S_HI: begin
                    if (w_xfer) begin
                        r_hi    <= rx_data;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_xor   <= r_xor ^ rx_data;
`endif
                        r_state <= S_LO;
                    end
                end
                S_LO: begin
                    if (w_xfer) begin
                        r_wrData <= {r_hi, rx_data};
                        r_wrAddr <= r_addr;
                        r_wrEn   <= 1'b1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_xor    <= r_xor ^ rx_data;
`endif
                        r_state  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_wordCount <= r_wordCount + (ADDR_W+1)'(1);
                    if (w_isHalt) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_state <= S_CHK;
`else
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
`endif
                    end else if (w_lastAddr) begin
                        r_overflow <= 1'b1;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                        r_state    <= S_DONE;
                    end else begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_state <= S_HI;
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                S_CHK: begin
                    if (w_xfer) begin
                        r_chkErr <= (rx_data != r_xor);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= S_DONE;
                    end
                end
`endif
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a full-size instance and a 4-entry instance share the stimulus.
// A stream-level model predicts every write; a per-cycle compare process checks the selected instance.
module tb_program_loader;

    localparam int DEPTH_A = 2048;
    localparam int DEPTH_B = 4;

    typedef struct {
        logic [10:0] a;
        logic [15:0] d;
    } wr_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        selB;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        startA, startB;

    logic        rdyA, enA, busyA, doneA, ovfA, chkA;
    logic [10:0] addrA;
    logic [15:0] dataA;
    logic [11:0] cntA;
    logic        rdyB, enB, busyB, doneB, ovfB, chkB;
    logic [1:0]  addrB;
    logic [15:0] dataB;
    logic [2:0]  cntB;

    logic        rdy, wEn, busy, done, ovf, chk;
    logic [10:0] wAddr;
    logic [15:0] wData;
    logic [11:0] cnt;

    int          checks = 0;
    int          errors = 0;

    logic [7:0]  stim[$];
    wr_t         expQ[$];
    wr_t         wrLog[$];
    int          dataTotal = 0;
    int          nAccept = 0;
    int          byteIdx = 0;
    int          expCount = 0;
    bit          loadActive = 1'b0;
    bit          prevLow = 1'b0;
    bit          expChkByte = 1'b0;
    bit          expOvf = 1'b0;
    bit          expChkErr = 1'b0;
    logic [10:0] lastAddr[2];
    logic [15:0] lastData[2];

    always #5 clk = ~clk;

    assign startA = start & ~selB;
    assign startB = start & selB;

    program_loader #(.RAM_DEPTH(DEPTH_A)) dutA (
        .clka(clk), .rsta_n(rst_n), .start(startA), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdyA), .wr_addr(addrA), .wr_data(dataA), .wr_en(enA), .busy(busyA),
        .done(doneA), .overflow(ovfA), .word_count(cntA), .chk_err(chkA)
    );

    program_loader #(.RAM_DEPTH(DEPTH_B)) dutB (
        .clka(clk), .rsta_n(rst_n), .start(startB), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rdyB), .wr_addr(addrB), .wr_data(dataB), .wr_en(enB), .busy(busyB),
        .done(doneB), .overflow(ovfB), .word_count(cntB), .chk_err(chkB)
    );

    assign rdy   = selB ? rdyB  : rdyA;
    assign wEn   = selB ? enB   : enA;
    assign busy  = selB ? busyB : busyA;
    assign done  = selB ? doneB : doneA;
    assign ovf   = selB ? ovfB  : ovfA;
    assign chk   = selB ? chkB  : chkA;
    assign wAddr = selB ? {9'd0, addrB} : addrA;
    assign wData = selB ? dataB : dataA;
    assign cnt   = selB ? {9'd0, cntB} : cntA;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic reportFail(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    endtask

    // Splits the byte stream into words, stopping at the halt word or the last address.
    function automatic void buildModel(input int depth);
        int         n;
        bit         halted;
        logic [7:0] x;
        logic [15:0] w;
        wr_t        e;
        n = 0;
        halted = 1'b0;
        x = 8'h00;
        expOvf = 1'b0;
        expQ.delete();
        wrLog.delete();
        for (int i = 0; i + 1 < stim.size(); i += 2) begin
            w = {stim[i], stim[i+1]};
            x = x ^ stim[i] ^ stim[i+1];
            e.a = 11'(n);
            e.d = w;
            expQ.push_back(e);
            n++;
            if (w == 16'h0000) begin
                halted = 1'b1;
                break;
            end
            if (n == depth) begin
                expOvf = 1'b1;
                break;
            end
        end
        dataTotal = 2 * n;
        expCount  = n;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        expChkByte = halted;
`else
        expChkByte = 1'b0;
`endif
        nAccept   = dataTotal + (expChkByte ? 1 : 0);
        expChkErr = expChkByte && (dataTotal < stim.size()) && (stim[dataTotal] != x);
    endfunction

    always @(negedge clk) begin
        wr_t e;
        if (!rst_n) begin
            expQ.delete();
            loadActive = 1'b0;
            prevLow    = 1'b0;
            byteIdx    = 0;
            lastAddr[0] = '0; lastAddr[1] = '0;
            lastData[0] = '0; lastData[1] = '0;
        end else begin
            checkOutput("wrEnTiming", wEn, prevLow);
            if (wEn) begin
                if (expQ.size() > 0) begin
                    e = expQ.pop_front();
                    checkOutput("wrAddr", wAddr, e.a);
                    checkOutput("wrData", wData, e.d);
                end else begin
                    reportFail("unexpectedWrite", wData, 0);
                end
                e.a = wAddr;
                e.d = wData;
                wrLog.push_back(e);
                lastAddr[selB] = wAddr;
                lastData[selB] = wData;
            end else begin
                checkOutput("wrAddrHold", wAddr, lastAddr[selB]);
                checkOutput("wrDataHold", wData, lastData[selB]);
            end
            checkOutput("rxReadyVsBusy", rdy, busy & ~wEn);
`ifndef PROGRAM_LOADER_CHECKSUM_EN
            checkOutput("chkErrTied", chk, 0);
`endif
            prevLow = 1'b0;
            if (rx_valid && rdy) begin
                if (!loadActive || byteIdx >= nAccept) begin
                    reportFail("unexpectedAccept", byteIdx, nAccept);
                end else begin
                    if (byteIdx < dataTotal) prevLow = (byteIdx % 2) == 1;
                    byteIdx++;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic sendByte(input logic [7:0] b, input bit expectTake, input int gap);
        int waited;
        bit taken;
        int limit;
        waited = 0;
        taken  = 1'b0;
        limit  = expectTake ? 60 : 8;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!taken && waited < limit) begin
            @(negedge clk);
            if (rdy) taken = 1'b1;
            @(posedge clk);
            #1;
            waited++;
        end
        rx_valid = 1'b0;
        if (expectTake && !taken) reportFail("byteTimeout", 0, 1);
        if (!expectTake) checkOutput("byteRefused", taken, 0);
        repeat (gap) tick();
    endtask

    task automatic waitDone();
        int w;
        w = 0;
        @(negedge clk);
        while (!done && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!done) reportFail("doneTimeout", done, 1);
        #1;
    endtask

    task automatic applyStimulus(input int gap, input int midStart);
        buildModel(selB ? DEPTH_B : DEPTH_A);
        byteIdx    = 0;
        loadActive = 1'b1;
        pulseStart();
        for (int i = 0; i < stim.size(); i++) begin
            if (i == midStart) pulseStart();
            sendByte(stim[i], i < nAccept, gap);
        end
        waitDone();
        checkOutput("done", done, 1);
        checkOutput("busy", busy, 0);
        checkOutput("overflow", ovf, expOvf);
        checkOutput("wordCount", cnt, expCount);
        checkOutput("chkErr", chk, expChkErr);
        checkOutput("writesPending", expQ.size(), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        selB     = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #1;
        checkOutput("resetBusy", busyA, 0);
        checkOutput("resetDone", doneA, 0);
        checkOutput("resetWrEn", enA, 0);
        checkOutput("resetCount", cntA, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] byte offered in IDLE must not be consumed");
        rx_data  = 8'h55;
        rx_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("idleRxReady", rdy, 0);
        end
        #1;
        rx_valid = 1'b0;
        tick();

        $display("[TB] basic load, rx_valid held high");
        stim = '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h00, 8'h40};
        applyStimulus(0, -1);
        checkOutput("basicWrites", wrLog.size(), 3);
        checkOutput("basicData0", wrLog[0].d, 16'h1234);
        checkOutput("basicData1", wrLog[1].d, 16'hABCD);
        checkOutput("basicAddr2", wrLog[2].a, 2);
        checkOutput("basicCount", cnt, 3);

        $display("[TB] same load with five idle cycles between bytes");
        applyStimulus(5, -1);
        checkOutput("gapWrites", wrLog.size(), 3);
        checkOutput("gapData1", wrLog[1].d, 16'hABCD);

        $display("[TB] start pulsed mid-load is ignored");
        applyStimulus(0, 2);
        checkOutput("midStartAddr2", wrLog[2].a, 2);
        checkOutput("midStartCount", cnt, 3);

        $display("[TB] overflow on a four-entry memory");
        selB = 1'b1;
        tick();
        stim = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
        applyStimulus(0, -1);
        checkOutput("ovfFlag", ovf, 1);
        checkOutput("ovfCount", cnt, 4);
        checkOutput("ovfAddr3", wrLog[3].a, 3);
        checkOutput("ovfData3", wrLog[3].d, 16'h0708);
        selB = 1'b0;
        tick();

        $display("[TB] reset in the middle of a load");
        stim = '{8'h12, 8'h34, 8'hAB, 8'hCD};
        buildModel(DEPTH_A);
        byteIdx    = 0;
        loadActive = 1'b1;
        pulseStart();
        sendByte(8'h12, 1'b1, 0);
        sendByte(8'h34, 1'b1, 0);
        sendByte(8'hAB, 1'b1, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midResetBusy", busyA, 0);
        checkOutput("midResetData", dataA, 0);
        checkOutput("midResetCount", cntA, 0);
        checkOutput("midResetReady", rdyA, 0);
        checkOutput("midResetWrEn", enA, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        stim = '{8'h00, 8'h00, 8'h00};
        applyStimulus(0, -1);
        checkOutput("afterResetWrites", wrLog.size(), 1);
        checkOutput("afterResetCount", cnt, 1);

        $display("[TB] checksum byte, matching then mismatching");
        stim = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h26};
        applyStimulus(0, -1);
        checkOutput("chkGoodLiteral", chk, 0);
        stim = '{8'h12, 8'h34, 8'h00, 8'h00, 8'h27};
        applyStimulus(0, -1);
`ifdef PROGRAM_LOADER_CHECKSUM_EN
        checkOutput("chkBadLiteral", chk, 1);
`else
        checkOutput("chkBadLiteral", chk, 0);
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Write-side companion of the read-only program memory.
- Accepts a byte stream over a valid/ready handshake, normally from the UART receiver during boot/debug.
- Assembles the bytes into RAM_WIDTH-bit instruction words and drives a synchronous write port (address, data, write enable) into a writable program memory.
- Stops on a halt word or when memory is full, then reports done.

Parameters:
- RAM_WIDTH, 16, instruction word width; fixed at 16 (two bytes per word).
- RAM_DEPTH, 2048, number of program memory entries.
- ADDR_W, clogb2(RAM_DEPTH-1), address width; derived, not overridden.
- HALT_WORD, 16'h0000, word that terminates a load; it is written before stopping.

Ports:
- clka  input  1  clock.
- rsta_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle pulse that begins a load.
- rx_data  input  8  incoming byte.
- rx_valid  input  1  rx_data is valid.
- rx_ready  output  1  loader accepts the byte this cycle.
- wr_addr  output  ADDR_W  program memory write address.
- wr_data  output  RAM_WIDTH  program memory write data.
- wr_en  output  1  write strobe, one cycle per word.
- busy  output  1  load in progress.
- done  output  1  load finished; level, held until the next accepted start.
- overflow  output  1  memory filled without a halt word.
- word_count  output  ADDR_W+1  words written in the current or last load.
- chk_err  output  1  checksum mismatch; tied 0 when the optional feature is absent.

Behaviour:
- Reset (async, rsta_n=0):
  - State IDLE.
  - All outputs 0, internal address 0.
  - Reset mid-load abandons the load immediately; no further wr_en is issued.
- A byte transfer occurs on a clka edge where rx_valid=1 and rx_ready=1.
- rx_ready is combinational from state only: 1 in HI, LO and CHK; 0 otherwise.
- States:
  - IDLE: waits for start. On start, clear address, word_count, done, overflow, chk_err and the running XOR, then go to HI.
  - HI: on transfer, latch byte as word[15:8]; go to LO.
  - LO: on transfer, latch byte as word[7:0]; go to WRITE. Byte order is big-endian (high byte first).
  - WRITE, one cycle:
    - wr_en=1, wr_addr=current address, wr_data={hi,lo}; word_count increments.
    - Then, in priority order:
      - if the word equals HALT_WORD, go to CHK (feature on) or DONE (feature off);
      - else if address equals RAM_DEPTH-1, set overflow=1 and go to DONE (no checksum byte consumed);
      - else increment the address and go to HI.
  - CHK: feature only; see Optional Feature.
  - DONE: done=1; on start, behave as from IDLE.
- busy=1 in HI, LO, WRITE and CHK; 0 in IDLE and DONE.
- Latency: wr_en is asserted in the cycle immediately after the low byte is accepted. Minimum 3 cycles per word with rx_valid held high.
- wr_addr and wr_data hold their last values when wr_en=0. wr_en is never asserted outside WRITE.
- start while busy=1 is ignored.
- rx_valid in IDLE or DONE is not consumed (rx_ready=0). The upstream source keeps the byte.
- Gaps in rx_valid stall the FSM indefinitely with no timeout.
- word_count counts every write, including the halt word. Maximum value is RAM_DEPTH.

Optional Feature:
- Macro PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - A running XOR of every data byte accepted in HI/LO is kept, including the halt word's bytes.
  - After the halt word is written, the FSM enters CHK, accepts one more byte, sets chk_err = (byte != running XOR), then goes to DONE.
  - chk_err holds until the next accepted start.
- Undefined:
  - No CHK state, no XOR register.
  - The halt word leads straight to DONE; chk_err is constant 0.

Test Plan:
- Bytes 12 34 AB CD 00 00, rx_valid held high -> three writes: addr0=1234, addr1=ABCD, addr2=0000. Each wr_en is exactly one cycle, 1 cycle after the low byte. Then word_count=3, done=1, busy=0, overflow=0.
- Same stream with rx_valid low for 5 cycles between every byte -> identical writes and data; no duplicate or missing wr_en.
- RAM_DEPTH=4, stream of five nonzero words -> writes at addr0..3, then overflow=1, done=1, word_count=4. The ninth byte is not accepted (rx_ready=0).
- Reset asserted after 12 34 AB -> outputs 0 immediately. A new start plus 00 00 writes only addr0=0000.
- start pulsed while busy, and rx_valid=1 in IDLE -> start ignored, address not cleared, no IDLE byte consumed.
- With PROGRAM_LOADER_CHECKSUM_EN: 12 34 00 00 then 26 -> chk_err=0, done=1. Repeating with final byte 27 -> chk_err=1.
